ddr2_axi_wr_arbiter: RTL
========================

Name: ddr2_axi_wr_arbiter

Overview:
- Two-requester AXI write-channel arbiter in front of the DDR2 controller's single AXI write slave port (AW/W/B subset: no IDs, no strobes).
- Arbitrates round-robin and locks the grant for one whole transaction: address, all data beats, then response.
- Counts W beats against awlen and flags burst-length mismatches.
- Lets the test master and a second traffic source (e.g. refresh-test or DMA generator) share the controller.

Parameters:
- ADDR_WIDTH, 25, byte/word address width (ROW+COL+BA bits).
- DATA_WIDTH, 32, W data width (2*DQ bits).

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- m0_awvalid/m1_awvalid  input  1  requester write address valid
- m0_awready/m1_awready  output  1  address accepted
- m0_awaddr/m1_awaddr  input  ADDR_WIDTH  write address
- m0_awlen/m1_awlen  input  8  beats minus one
- m0_wvalid/m1_wvalid  input  1  data valid
- m0_wready/m1_wready  output  1  data accepted
- m0_wlast/m1_wlast  input  1  last beat
- m0_wdata/m1_wdata  input  DATA_WIDTH  write data
- m0_bvalid/m1_bvalid  output  1  response valid
- m0_bready/m1_bready  input  1  response accept
- s_awvalid  output  1;  s_awready  input  1;  s_awaddr  output  ADDR_WIDTH;  s_awlen  output  8
- s_wvalid  output  1;  s_wready  input  1;  s_wlast  output  1;  s_wdata  output  DATA_WIDTH
- s_bvalid  input  1;  s_bready  output  1
- grant  output  2  one-hot owner (bit0=m0, bit1=m1), 0 when idle
- len_err  output  1  sticky burst-length mismatch flag
- len_err_clr  input  1  synchronous clear of len_err

Behaviour:
- Reset (rstn low, async): state IDLE, grant=0, last_owner=m1 (so m0 wins the first tie), beat_cnt=0, len_err=0. All s_* valids/readies and all m*_ readies/bvalid are 0. Mid-transaction reset abandons the burst; no response is generated.
- States: IDLE, ADDR, DATA, RESP.
- IDLE: if either awvalid is high, register the owner.
  - Only one requesting: that one.
  - Both requesting: the one that is not last_owner.
  - Then grant<=owner one-hot and go to ADDR. One cycle arbitration latency; no s_* activity in IDLE.
- ADDR: s_awvalid/awaddr/awlen are combinationally muxed from the owner; owner awready = s_awready. On s_awvalid&s_awready, latch awlen into len_q, beat_cnt<=0, go to DATA.
- DATA:
  - s_wvalid/wdata/wlast come from the owner; owner wready = s_wready.
  - Each handshake increments beat_cnt (9 bits).
  - On a handshake with wlast: if beat_cnt+1 != len_q+1, set len_err. Go to RESP.
  - A beat count of 256 without wlast sets len_err but the state stays DATA; wlast is the only exit.
- RESP: owner bvalid = s_bvalid; s_bready = owner bready. On handshake: last_owner<=owner, grant<=0, go to IDLE.
- The non-owner always sees awready=wready=bvalid=0, and its valids are ignored. A request that arrives mid-transaction waits; it is served next if it is still asserted in IDLE.
- Back-to-back: IDLE is always visited, so there is at least one idle slave cycle between transactions.
- len_err_clr clears len_err. If a clear and a new error occur in the same cycle, set wins.
- Widths: beat_cnt 9 bits, compared against zero-extended len_q+1.

Test Plan:
- Single m0 burst, awaddr=16, awlen=7, 8 beats data 0..7, s_* always ready: exactly 8 s_w handshakes with s_wlast on the 8th. m0_bvalid is asserted; grant=01 from the cycle after awvalid until the B handshake. len_err=0.
- m0 and m1 assert awvalid in the same cycle after reset: m0 is served first, then m1. A second simultaneous request goes to m0 again (round-robin alternation 01,10,01).
- s_awready held low 5 cycles, s_wready toggling every other cycle: no beat is lost or duplicated, and wdata order is preserved.
- m1 requests during m0's DATA phase: m1_awready stays 0 until m0's B handshake; m1 is granted in the following IDLE.
- awlen=7 but wlast on beat 4: len_err=1 and the FSM returns to IDLE after B. len_err_clr=1 for one cycle gives len_err=0.
- rstn pulsed low in DATA after beat 3: all outputs are 0 immediately; after release a fresh m0 burst completes normally.

Source files
------------

// File: rtl/ddr2_axi_wr_arbiter.sv
// Two-requester round-robin arbiter for the DDR2 controller's AXI write slave port.
// The grant is held for a whole AW/W/B transaction and W beats are checked against awlen.
module ddr2_axi_wr_arbiter #(
  parameter int ADDR_WIDTH = 25,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  m0_awvalid,
  output logic                  m0_awready,
  input  logic [ADDR_WIDTH-1:0] m0_awaddr,
  input  logic [7:0]            m0_awlen,
  input  logic                  m0_wvalid,
  output logic                  m0_wready,
  input  logic                  m0_wlast,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_bvalid,
  input  logic                  m0_bready,

  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [ADDR_WIDTH-1:0] m1_awaddr,
  input  logic [7:0]            m1_awlen,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  input  logic                  m1_wlast,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,

  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [ADDR_WIDTH-1:0] s_awaddr,
  output logic [7:0]            s_awlen,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  output logic                  s_wlast,
  output logic [DATA_WIDTH-1:0] s_wdata,
  input  logic                  s_bvalid,
  output logic                  s_bready,

  output logic [1:0]            grant,
  output logic                  len_err,
  input  logic                  len_err_clr
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t state, state_nxt;

  logic                  owner;
  logic                  last_owner;
  logic                  any_req;
  logic                  arb_sel;
  logic [8:0]            beat_cnt;
  logic [8:0]            beat_cnt_inc;
  logic [8:0]            len_plus;
  logic [7:0]            len_q;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  len_err_set;

  logic                  own_awvalid;
  logic [ADDR_WIDTH-1:0] own_awaddr;
  logic [7:0]            own_awlen;
  logic                  own_wvalid;
  logic                  own_wlast;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic                  own_bready;

  assign own_awvalid = owner ? m1_awvalid : m0_awvalid;
  assign own_awaddr  = owner ? m1_awaddr  : m0_awaddr;
  assign own_awlen   = owner ? m1_awlen   : m0_awlen;
  assign own_wvalid  = owner ? m1_wvalid  : m0_wvalid;
  assign own_wlast   = owner ? m1_wlast   : m0_wlast;
  assign own_wdata   = owner ? m1_wdata   : m0_wdata;
  assign own_bready  = owner ? m1_bready  : m0_bready;

  // On a tie the requester that was not served last wins.
  assign any_req = m0_awvalid | m1_awvalid;
  assign arb_sel = (m0_awvalid & m1_awvalid) ? ~last_owner : m1_awvalid;

  assign aw_hs = (state == ADDR) & own_awvalid & s_awready;
  assign w_hs  = (state == DATA) & own_wvalid  & s_wready;
  assign b_hs  = (state == RESP) & s_bvalid    & own_bready;

  assign beat_cnt_inc = beat_cnt + 9'd1;
  assign len_plus     = {1'b0, len_q} + 9'd1;
  // Wrong count on wlast, or a 256th beat that still is not last.
  assign len_err_set  = w_hs & (own_wlast ? (beat_cnt_inc != len_plus)
                                          : (beat_cnt_inc == 9'd256));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    s_awvalid  = 1'b0;
    s_awaddr   = '0;
    s_awlen    = '0;
    s_wvalid   = 1'b0;
    s_wlast    = 1'b0;
    s_wdata    = '0;
    s_bready   = 1'b0;
    m0_awready = 1'b0;
    m1_awready = 1'b0;
    m0_wready  = 1'b0;
    m1_wready  = 1'b0;
    m0_bvalid  = 1'b0;
    m1_bvalid  = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ADDR;
      end
      ADDR: begin
        s_awvalid  = own_awvalid;
        s_awaddr   = own_awaddr;
        s_awlen    = own_awlen;
        m0_awready = ~owner & s_awready;
        m1_awready =  owner & s_awready;
        if (aw_hs) state_nxt = DATA;
      end
      DATA: begin
        s_wvalid  = own_wvalid;
        s_wdata   = own_wdata;
        s_wlast   = own_wlast;
        m0_wready = ~owner & s_wready;
        m1_wready =  owner & s_wready;
        if (w_hs & own_wlast) state_nxt = RESP;
      end
      RESP: begin
        s_bready  = own_bready;
        m0_bvalid = ~owner & s_bvalid;
        m1_bvalid =  owner & s_bvalid;
        if (b_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      grant      <= 2'b00;
      beat_cnt   <= '0;
      len_q      <= '0;
    end else begin
      if ((state == IDLE) && any_req) begin
        owner <= arb_sel;
        grant <= arb_sel ? 2'b10 : 2'b01;
      end
      if (aw_hs) begin
        len_q    <= own_awlen;
        beat_cnt <= '0;
      end
      if (w_hs) beat_cnt <= beat_cnt_inc;
      if (b_hs) begin
        last_owner <= owner;
        grant      <= 2'b00;
      end
    end
  end

  // Sticky error: a new error in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            len_err <= 1'b0;
    else if (len_err_set) len_err <= 1'b1;
    else if (len_err_clr) len_err <= 1'b0;
  end

endmodule
